dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter and sequencer for the 256×8 data memory. It shares the memory's single write/read port between the core load/store unit (master 0) and the program/data loader (master 1). It uses round-robin arbitration and supports optional locked bursts. It drives the memory's `we`/`addr`/`di` and returns `dout` through a registered read-response path.

## Interface
- `AW`, default 8: address width; matches the memory's depth of 256.
- `DW`, default 8: data width.
- `MAX_LOCK`, default 8: maximum consecutive locked beats before a forced release. Legal range is 1–255.
- `clk  in  1`: clock. All state changes on the rising edge.
- `rst_n  in  1`: reset. Asynchronous, active-low.
- `mN_req  in  1`: master N requests a beat (N = 0, 1).
- `mN_we  in  1`: 1 = write beat, 0 = read beat.
- `mN_lock  in  1`: hold ownership after this beat.
- `mN_addr  in  AW`: beat address.
- `mN_wdata  in  DW`: write data.
- `mN_gnt  out  1`: beat accepted this cycle. Combinational.
- `mN_rvalid  out  1`: read data valid. One-cycle pulse.
- `mN_rdata  out  DW`: read data. Registered.
- `mem_we  out  1`: to memory `we`.
- `mem_addr  out  AW`: to memory `addr`.
- `mem_di  out  DW`: to memory `di`.
- `mem_dout  in  DW`: from memory `dout`, which is a combinational read.
- `owner  out  2`: 00 = none, 01 = m0 granted, 10 = m1 granted. Combinational, mirrors `gnt`.

## Operation
- A beat is accepted when `mN_req & mN_gnt`. At most one `gnt` is high per cycle.
- Memory muxing:
  - Granted master's `addr`/`wdata` drive `mem_addr`/`mem_di`.
  - `mem_we = gnt & we`.
  - With no grant: `mem_we`=0, `mem_addr`=0, `mem_di`=0.
- State machine: `ARB`, `LOCK0`, `LOCK1`. Reset state is `ARB`.
- Behaviour in `ARB`:
  - A single requester is granted.
  - If both request, the master that is not `last` is granted.
  - `last` updates to the winner on each accept and resets to 1, so m0 wins the first contest.
- Entering a lock: in `ARB`, an accept with `lock`=1 moves to `LOCKn` and sets `lock_cnt`=1.
- Behaviour in `LOCKn`:
  - Only master n can be granted. The other master sees `gnt`=0 even while requesting.
  - If the owner holds `req`=0, no one is granted and the state is held.
  - Each owner accept increments `lock_cnt`.
- Leaving `LOCKn` (return to `ARB`):
  - on an owner accept with `lock`=0, or
  - when an accept brings `lock_cnt` to `MAX_LOCK`, regardless of `lock` (forced release).
  - On exit, `last`=n, so the other master wins the next contest.
- `lock_cnt` width is `$clog2(MAX_LOCK+1)`. It never wraps: it clears on entry to `ARB`.
- Read response:
  - On a read accept, `mem_dout` is captured into `mN_rdata` at the edge.
  - `mN_rvalid` is high for exactly the following cycle.
  - `rdata` holds its value until the next read for that master.
- Write: the memory commits at the accept edge. A read of the same address in the next cycle returns the new data.
- Back-to-back read and write by different masters on the same address are ordered by grant order.
- Reset values: state `ARB`, `last`=1, `lock_cnt`=0, both `rvalid`=0, both `rdata`=0. While `rst_n`=0, all `gnt` are forced to 0, so `mem_we`=0.
- Reset mid-burst: lock is dropped with no response. Any `rvalid` due in the next cycle is suppressed.

## Timing
- Grant latency: 0 cycles, combinational from `req` and registered state.
- Write latency: committed at the accept edge.
- Read latency: 1 cycle from accept to `rvalid`.
- Throughput: one beat per cycle, total across both masters.
- No combinational path from `mem_dout` to any output.

## Configuration
- Macro: `DMEM_ARB_LOCK_EN`.
- Defined: lock FSM as described above.
- Undefined:
  - `mN_lock` inputs are ignored.
  - FSM and `lock_cnt` are removed; the arbiter is pure round-robin.
  - `MAX_LOCK` has no effect.
  - Ports are unchanged.

## Structure
- `dmem_arb_pkg`:
  - `arb_state_e` (`ARB`, `LOCK0`, `LOCK1`)
  - `owner_t` (2-bit one-hot)
  - default `AW`/`DW` localparams
- Sub-module `rr_arb2`: combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `last`.
  - Output: `gnt[1:0]`.

## Test plan
- Reset, then m0 writes 0x5A to addr 0x10. Next cycle m0 reads 0x10, giving `m0_rvalid`=1 with `m0_rdata`=0x5A one cycle later, and `mem_we`=0 on the read cycle.
- Both masters request every cycle, no lock:
  - grants alternate m0, m1, m0, m1;
  - `owner` follows 01, 10, 01, 10.
- `DMEM_ARB_LOCK_EN`, `MAX_LOCK`=4:
  - m1 issues 6 locked beats while m0 requests continuously.
  - m1 is granted 4 beats, then m0 is granted, then m1.
- Locked m0 drops `req` for 3 cycles while m1 requests: no grants, `mem_we`=0, state stays `LOCK0`. m0 then sends a beat with `lock`=0, after which m1 is granted.
- Assert `rst_n`=0 mid-lock, the cycle after a read accept: `rvalid` stays 0, all `gnt` are 0 during reset, and after release m0 wins the first contest.
- Build without the macro: `lock`=1 on m0 each beat still gives alternation with a requesting m1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // One-hot ownership: bit 0 = m0, bit 1 = m1, all-zero = nobody.
    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'b00;
    localparam owner_t OWNER_M0   = 2'b01;
    localparam owner_t OWNER_M1   = 2'b10;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the master that did not win last time wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: a non-picked requester simply sees its gnt bit low.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output owner_t     gnt
);

    // Single requester wins outright; on a tie, last=1 (m1 won last) hands it to m0.
    always_comb begin
        gnt = OWNER_NONE;
        if (req == 2'b11) begin
            gnt = last ? OWNER_M0 : OWNER_M1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the 256x8 memory port between m0 (load/store) and m1 (loader); lock bursts under DMEM_ARB_LOCK_EN.
// Latency: grant 0 cycles (combinational), write commits at accept edge, read data 1 cycle after accept.
// Backpressure: a master holds req until it sees gnt; a locked owner that idles stalls the other master.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    owner
);

    logic   [1:0] req;
    owner_t       rr_gnt;
    owner_t       gnt;
    logic         last_q;   // 1 = m1 won the most recent accept

    assign req = {m1_req, m0_req};

    rr_arb2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt)
    );

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]    lock;

    assign lock = {m1_lock, m0_lock};

    // Grant selection plus lock entry/exit; a grant is always an accept since gnt implies req.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = OWNER_NONE;
        unique case (state_q)
            ARB: begin
                gnt = rr_gnt;
                // With MAX_LOCK=1 the very first beat already hits the limit, so never enter.
                if ((|(gnt & lock)) && (MAX_LOCK > 1)) begin
                    state_d    = gnt[0] ? LOCK0 : LOCK1;
                    lock_cnt_d = CW'(1);
                end
            end
            LOCK0, LOCK1: begin
                gnt = (state_q == LOCK0) ? {1'b0, req[0]} : {req[1], 1'b0};
                if (|gnt) begin
                    if (!(|(gnt & lock)) || (lock_cnt_q == CW'(MAX_LOCK - 1))) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
        if (!rst_n) begin
            gnt = OWNER_NONE;
        end
    end

    // Lock FSM state and beat counter; reset drops any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    localparam int unused_max_lock = MAX_LOCK;
    logic unused_lock;

    assign unused_lock = &{1'b0, m0_lock, m1_lock};

    // Pure round-robin: grants blocked only while reset is asserted.
    always_comb begin
        gnt = rst_n ? rr_gnt : OWNER_NONE;
    end
`endif

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign owner  = gnt;

    // Remember the winner of every accept; an exiting lock owner thus yields the next contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

    // Steer the granted master onto the memory port; idle port drives zeros.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        if (gnt[0]) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_di   = m0_wdata;
        end else if (gnt[1]) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_di   = m1_wdata;
        end
    end

    // Registered read return: capture mem_dout at the accept edge, pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt[0] & ~m0_we;
            m1_rvalid <= gnt[1] & ~m1_we;
            if (gnt[0] & ~m0_we) begin
                m0_rdata <= mem_dout;
            end
            if (gnt[1] & ~m1_we) begin
                m1_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a queue/array reference model.
// Latency: inputs driven at negedge, outputs compared 2 time units later, model advanced at posedge.
// Backpressure: masters keep req asserted until the model says they were granted (random phase re-rolls).
module tb_dmem_arbiter;

    localparam int MAXL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0;
    logic       m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [7:0] m1_addr = 0, m1_wdata = 0;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_di, mem_dout;
    logic [1:0] owner;

    dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Behavioural 256x8 memory with combinational read, written at the clock edge.
    logic [7:0] mem [256];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_di;
    assign mem_dout = mem[mem_addr];

    // Reference model state.
    logic [7:0] ref_mem [256];
    int m_lk;          // -1 = no lock held, else locked master
    int m_cnt;
    int m_last;
    int exp_rv [2];
    int exp_rd [2];
    int gseq [$];      // model grant per cycle (-1 = none)

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic set_m(input int n, input bit r, input bit w, input bit l, input int a, input int d);
        if (n == 0) begin
            m0_req = r; m0_we = w; m0_lock = l; m0_addr = 8'(a); m0_wdata = 8'(d);
        end else begin
            m1_req = r; m1_we = w; m1_lock = l; m1_addr = 8'(a); m1_wdata = 8'(d);
        end
    endtask

    // One clock cycle: compare every output against the model, then advance the model at the edge.
    task automatic cycle();
        int g;
        int nrv [2];
        bit r [2];
        bit w [2];
        bit l [2];
        int a [2];
        int d [2];
        #2;
        r[0] = m0_req; w[0] = m0_we; l[0] = m0_lock; a[0] = m0_addr; d[0] = m0_wdata;
        r[1] = m1_req; w[1] = m1_we; l[1] = m1_lock; a[1] = m1_addr; d[1] = m1_wdata;
        if (!rst_n) begin
            m_lk = -1; m_cnt = 0; m_last = 1;
            exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        end
        g = -1;
        if (rst_n) begin
            if (m_lk >= 0) g = r[m_lk] ? m_lk : -1;
            else if (r[0] && r[1]) g = (m_last == 1) ? 0 : 1;
            else if (r[0]) g = 0;
            else if (r[1]) g = 1;
        end
        chk("gnt0", int'(m0_gnt), int'(g == 0));
        chk("gnt1", int'(m1_gnt), int'(g == 1));
        chk("owner", int'(owner), (g == 0) ? 1 : (g == 1) ? 2 : 0);
        chk("mem_we", int'(mem_we), (g < 0) ? 0 : int'(w[g]));
        chk("mem_addr", int'(mem_addr), (g < 0) ? 0 : a[g]);
        chk("mem_di", int'(mem_di), (g < 0) ? 0 : d[g]);
        chk("rvalid0", int'(m0_rvalid), exp_rv[0]);
        chk("rvalid1", int'(m1_rvalid), exp_rv[1]);
        chk("rdata0", int'(m0_rdata), exp_rd[0]);
        chk("rdata1", int'(m1_rdata), exp_rd[1]);
        gseq.push_back(g);
        @(posedge clk);
        if (rst_n) begin
            nrv[0] = 0; nrv[1] = 0;
            if (g >= 0) begin
                if (w[g]) ref_mem[a[g]] = 8'(d[g]);
                else begin
                    nrv[g] = 1;
                    exp_rd[g] = ref_mem[a[g]];
                end
                m_last = g;
`ifdef DMEM_ARB_LOCK_EN
                if (m_lk < 0) begin
                    if (l[g] && MAXL > 1) begin m_lk = g; m_cnt = 1; end
                end else begin
                    m_cnt++;
                    if (!l[g] || m_cnt == MAXL) begin m_lk = -1; m_cnt = 0; end
                end
`endif
            end
            exp_rv[0] = nrv[0]; exp_rv[1] = nrv[1];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic chk_seq(input string nm, input int start, input int exp [$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (start + i < gseq.size()) chk(nm, gseq[start + i], exp[i]);
            else chk({nm, "_missing"}, -2, exp[i]);
        end
    endtask

    int s;
    int m1_beats;
    int e_alt [$] = '{0, 1, 0, 1};
    int e_lock [$] = '{1, 1, 1, 1, 0, 1, 1};
    int e_hold [$] = '{0, -1, -1, -1, 0, 1};

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        m_lk = -1; m_cnt = 0; m_last = 1;
        exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        @(negedge clk);
        // Reset with both masters requesting: nothing may be granted.
        set_m(0, 1, 1, 1, 3, 7);
        set_m(1, 1, 1, 1, 4, 8);
        apply_reset();
        idle();

        // Write 0x5A to 0x10, read it back the following cycle.
        set_m(0, 1, 1, 0, 8'h10, 8'h5A);
        cycle();
        set_m(0, 1, 0, 0, 8'h10, 0);
        #1 chk("rd_cycle_mem_we", int'(mem_we), 0);
        cycle();
        idle();
        #1;
        chk("rd_rvalid", int'(m0_rvalid), 1);
        chk("rd_rdata", int'(m0_rdata), 8'h5A);
        cycle();

        // Both masters contend every cycle from reset: strict alternation.
        apply_reset();
        s = gseq.size();
        for (int i = 0; i < 4; i++) begin
            set_m(0, 1, 0, 0, i, 0);
            set_m(1, 1, 0, 0, i + 8, 0);
            cycle();
        end
        chk_seq("alternate", s, e_alt);
        idle();

`ifdef DMEM_ARB_LOCK_EN
        // m1 issues 6 locked beats while m0 requests continuously.
        apply_reset();
        s = gseq.size();
        m1_beats = 0;
        set_m(1, 1, 1, 1, 8'h20, 1);
        cycle();
        if (gseq[$] == 1) m1_beats++;
        for (int i = 0; i < 12 && m1_beats < 6; i++) begin
            set_m(0, 1, 0, 0, 8'h21, 0);
            set_m(1, 1, 1, 1, 8'h20 + m1_beats, m1_beats);
            cycle();
            if (gseq[$] == 1) m1_beats++;
        end
        chk_seq("lock_burst", s, e_lock);
        idle();

        // Locked m0 idles for three cycles while m1 waits, then releases.
        apply_reset();
        s = gseq.size();
        set_m(0, 1, 1, 1, 8'h30, 8'h11);
        cycle();
        idle();
        set_m(1, 1, 1, 0, 8'h31, 8'h22);
        for (int i = 0; i < 3; i++) cycle();
        set_m(0, 1, 1, 0, 8'h32, 8'h33);
        cycle();
        set_m(0, 0, 0, 0, 0, 0);
        cycle();
        chk_seq("lock_hold", s, e_hold);
        idle();
`else
        // lock inputs ignored: m0 asserting lock still alternates with m1.
        apply_reset();
        s = gseq.size();
        for (int i = 0; i < 4; i++) begin
            set_m(0, 1, 1, 1, 8'h40 + i, i);
            set_m(1, 1, 0, 0, 8'h48 + i, 0);
            cycle();
        end
        chk_seq("nolock_alt", s, e_alt);
        idle();
`endif

        // Reset the cycle after a locked read accept: response is dropped.
        set_m(0, 1, 0, 1, 8'h10, 0);
        cycle();
        set_m(1, 1, 0, 0, 8'h11, 0);
        rst_n = 1'b0;
        #2;
        chk("rst_rvalid0", int'(m0_rvalid), 0);
        chk("rst_gnt0", int'(m0_gnt), 0);
        chk("rst_gnt1", int'(m1_gnt), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_first_winner", gseq[$], 0);
        idle();

        // Randomized traffic with a small address window to exercise same-address hazards.
        for (int i = 0; i < 600; i++) begin
            set_m(0, $urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 255));
            set_m(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
